// File: rtl/ui_input_conditioner.sv
// rtl/ui_input_conditioner.sv - synchronize, debounce and capture sticky events for board keys and switches
module ui_input_conditioner #(
    parameter int NKEYS      = 4,
    parameter int NSW        = 10,
    parameter int DEB_CYCLES = 255,
    parameter int CNT_BITS   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] KEYS,
    input  logic [NSW-1:0]   SWITCHES,
    input  logic             clrEn,
    input  logic [NKEYS-1:0] clrKeyMask,
    input  logic             clrSw,
    output logic [NKEYS-1:0] keyValue,
    output logic [NSW-1:0]   switchValue,
    output logic [NKEYS-1:0] keyEvent,
    output logic [NKEYS-1:0] keyOverrun,
    output logic             swChanged,
    output logic             irq
);

    // Keys and switches share one debounce datapath; keys occupy the low bits.
    localparam int NB = NKEYS + NSW;
    // Keys idle high (released), switches idle low.
    localparam logic [NB-1:0] RST_V = {{NSW{1'b0}}, {NKEYS{1'b1}}};
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEB_CYCLES - 1);

    logic [NB-1:0]       raw;
    logic [NB-1:0]       sync1_q;
    logic [NB-1:0]       sync2_q;
    logic [NB-1:0]       deb_q;
    logic [NB-1:0]       deb_d;
    logic [CNT_BITS-1:0] cnt_q [NB];
    logic [CNT_BITS-1:0] cnt_d [NB];

    logic [NKEYS-1:0]    key_event_q;
    logic [NKEYS-1:0]    key_event_d;
    logic [NKEYS-1:0]    key_ovr_q;
    logic [NKEYS-1:0]    key_ovr_d;
    logic                sw_changed_q;
    logic                sw_changed_d;

    logic [NKEYS-1:0]    key_fall;
    logic [NKEYS-1:0]    key_clr;
    logic                sw_delta;

    assign raw = {SWITCHES, KEYS};

    // Per-bit debounce: count consecutive cycles where s differs from d; any agreement restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

    // Sticky events: a set on the same edge as a clear wins, and overrun looks at the pre-clear event bit.
    always_comb begin
        key_fall     = deb_q[NKEYS-1:0] & ~deb_d[NKEYS-1:0];
        sw_delta     = |(deb_q[NB-1:NKEYS] ^ deb_d[NB-1:NKEYS]);
        key_clr      = clrEn ? clrKeyMask : '0;
        key_ovr_d    = (key_ovr_q & ~key_clr) | (key_fall & key_event_q);
        key_event_d  = (key_event_q & ~key_clr) | key_fall;
        sw_changed_d = (sw_changed_q & ~(clrEn & clrSw)) | sw_delta;
    end

    // Synchronizers, debounce state and event registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= RST_V;
            sync2_q      <= RST_V;
            deb_q        <= RST_V;
            key_event_q  <= '0;
            key_ovr_q    <= '0;
            sw_changed_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            key_event_q  <= key_event_d;
            key_ovr_q    <= key_ovr_d;
            sw_changed_q <= sw_changed_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keyValue    = deb_q[NKEYS-1:0];
    assign switchValue = deb_q[NB-1:NKEYS];
    assign keyEvent    = key_event_q;
    assign keyOverrun  = key_ovr_q;
    assign swChanged   = sw_changed_q;
    assign irq         = (|key_event_q) | sw_changed_q;

endmodule

// File: tb/tb_ui_input_conditioner.sv
// tb/tb_ui_input_conditioner.sv - directed and randomized checks of ui_input_conditioner against a window-based model
module tb_ui_input_conditioner;

    localparam int NKEYS = 4;
    localparam int NSW   = 10;
    localparam int DEB   = 4;
    localparam int CNTB  = 3;
    localparam int NB    = NKEYS + NSW;
    localparam logic [NB-1:0] RST_V = {{NSW{1'b0}}, {NKEYS{1'b1}}};

    logic             clk = 1'b0;
    logic             reset;
    logic [NKEYS-1:0] KEYS;
    logic [NSW-1:0]   SWITCHES;
    logic             clrEn;
    logic [NKEYS-1:0] clrKeyMask;
    logic             clrSw;
    logic [NKEYS-1:0] keyValue;
    logic [NSW-1:0]   switchValue;
    logic [NKEYS-1:0] keyEvent;
    logic [NKEYS-1:0] keyOverrun;
    logic             swChanged;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    ui_input_conditioner #(
        .NKEYS(NKEYS), .NSW(NSW), .DEB_CYCLES(DEB), .CNT_BITS(CNTB)
    ) dut (
        .clk(clk), .reset(reset), .KEYS(KEYS), .SWITCHES(SWITCHES),
        .clrEn(clrEn), .clrKeyMask(clrKeyMask), .clrSw(clrSw),
        .keyValue(keyValue), .switchValue(switchValue), .keyEvent(keyEvent),
        .keyOverrun(keyOverrun), .swChanged(swChanged), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a bit's debounced value flips once the last DEB synchronized samples all disagree with it.
    logic [NB-1:0]    m_sync1, m_s, m_d;
    logic [NB-1:0]    m_win [DEB];
    logic [NKEYS-1:0] m_kev, m_kovr;
    logic             m_swc;

    task automatic model_reset();
        m_sync1 = RST_V;
        m_s     = RST_V;
        m_d     = RST_V;
        for (int j = 0; j < DEB; j++) m_win[j] = RST_V;
        m_kev   = '0;
        m_kovr  = '0;
        m_swc   = 1'b0;
    endtask

    task automatic model_edge();
        logic [NB-1:0]    alldiff, new_d;
        logic [NKEYS-1:0] fall, clrk;
        if (reset) begin
            model_reset();
        end else begin
            for (int j = DEB - 1; j > 0; j--) m_win[j] = m_win[j-1];
            m_win[0] = m_s;
            alldiff = '1;
            for (int j = 0; j < DEB; j++) alldiff = alldiff & (m_win[j] ^ m_d);
            new_d  = m_d ^ alldiff;
            fall   = m_d[NKEYS-1:0] & ~new_d[NKEYS-1:0];
            clrk   = clrEn ? clrKeyMask : '0;
            m_kovr = (m_kovr & ~clrk) | (fall & m_kev);
            m_kev  = (m_kev & ~clrk) | fall;
            m_swc  = (m_swc & ~(clrEn & clrSw)) | (new_d[NB-1:NKEYS] != m_d[NB-1:NKEYS]);
            m_d    = new_d;
            m_s    = m_sync1;
            m_sync1 = {SWITCHES, KEYS};
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("keyValue",    32'(keyValue),    32'(m_d[NKEYS-1:0]));
        chk("switchValue", 32'(switchValue), 32'(m_d[NB-1:NKEYS]));
        chk("keyEvent",    32'(keyEvent),    32'(m_kev));
        chk("keyOverrun",  32'(keyOverrun),  32'(m_kovr));
        chk("swChanged",   32'(swChanged),   32'(m_swc));
        chk("irq",         32'(irq),         32'((|m_kev) | m_swc));
    endtask

    // Inputs change 1 time unit after a rising edge, so the edge sees stable values.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_keyValue",    32'(keyValue),    32'hF);
        chk("rst_switchValue", 32'(switchValue), 32'h0);
        chk("rst_events",      32'({keyEvent, keyOverrun, swChanged}), 32'h0);
        chk("rst_irq",         32'(irq),         32'h0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_clr(input logic [NKEYS-1:0] mask, input logic sw);
        clrEn = 1'b1;
        clrKeyMask = mask;
        clrSw = sw;
        tick();
        clrEn = 1'b0;
        clrKeyMask = '0;
        clrSw = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        KEYS = 4'hF;
        SWITCHES = '0;
        clrEn = 1'b0;
        clrKeyMask = '0;
        clrSw = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Mid-cycle reset, then idle inputs must leave everything unchanged.
        #2;
        do_reset();
        repeat (20) tick();
        chk("idle_keyValue", 32'(keyValue), 32'hF);
        chk("idle_irq",      32'(irq),      32'h0);

        // Clean press of KEY2: debounced on the sixth edge counting the first sampling edge.
        KEYS[2] = 1'b0;
        repeat (5) tick();
        chk("press_early_keyValue", 32'(keyValue), 32'hF);
        tick();
        chk("press_keyValue", 32'(keyValue), 32'hB);
        chk("press_keyEvent", 32'(keyEvent), 32'h4);
        chk("press_irq",      32'(irq),      32'h1);
        repeat (4) tick();
        KEYS[2] = 1'b1;
        repeat (8) tick();
        chk("release_keyValue", 32'(keyValue), 32'hF);
        chk("release_keyEvent", 32'(keyEvent), 32'h4);

        // Bounce on KEY0 yields exactly one event.
        pulse_clr(4'hF, 1'b0);
        KEYS[0] = 1'b0; repeat (2) tick();
        KEYS[0] = 1'b1; repeat (2) tick();
        KEYS[0] = 1'b0; repeat (2) tick();
        KEYS[0] = 1'b1; repeat (2) tick();
        chk("bounce_stable", 32'(keyValue), 32'hF);
        KEYS[0] = 1'b0; repeat (12) tick();
        chk("bounce_keyEvent",   32'(keyEvent),   32'h1);
        chk("bounce_keyOverrun", 32'(keyOverrun), 32'h0);
        KEYS[0] = 1'b1; repeat (8) tick();
        pulse_clr(4'h1, 1'b0);

        // Two presses of KEY1 without a clear produce an overrun; a masked clear removes both.
        KEYS[1] = 1'b0; repeat (8) tick();
        KEYS[1] = 1'b1; repeat (8) tick();
        KEYS[1] = 1'b0; repeat (8) tick();
        chk("ovr_keyEvent",   32'(keyEvent),   32'h2);
        chk("ovr_keyOverrun", 32'(keyOverrun), 32'h2);
        KEYS[1] = 1'b1; repeat (8) tick();
        pulse_clr(4'h2, 1'b0);
        chk("clr_keyEvent",   32'(keyEvent),   32'h0);
        chk("clr_keyOverrun", 32'(keyOverrun), 32'h0);
        chk("clr_irq",        32'(irq),        32'h0);

        // Clear on the exact edge of a KEY0 debounced press: the set wins.
        KEYS[0] = 1'b0;
        repeat (5) tick();
        pulse_clr(4'h1, 1'b0);
        chk("collide_keyEvent", 32'(keyEvent), 32'h1);
        KEYS[0] = 1'b1; repeat (8) tick();
        pulse_clr(4'hF, 1'b0);

        // Switches, switch clear, and reset in the middle of a count.
        SWITCHES = 10'h2A5;
        repeat (5) tick();
        chk("sw_early", 32'(switchValue), 32'h0);
        tick();
        chk("sw_value",   32'(switchValue), 32'h2A5);
        chk("sw_changed", 32'(swChanged),   32'h1);
        pulse_clr(4'h0, 1'b1);
        chk("sw_clr", 32'(swChanged), 32'h0);
        SWITCHES = 10'h155;
        repeat (3) tick();
        #3;
        do_reset();
        repeat (8) tick();
        chk("sw_after_reset", 32'(switchValue), 32'h155);

        // Randomized traffic with occasional clears and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) KEYS[$urandom_range(0, NKEYS-1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) SWITCHES[$urandom_range(0, NSW-1)] ^= 1'b1;
            clrEn      = ($urandom_range(0, 9) == 0);
            clrKeyMask = NKEYS'($urandom);
            clrSw      = 1'($urandom);
            if (c == 300) begin
                #2;
                do_reset();
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
